// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the Data_Memory arbiter: FSM state encoding,
// grant identifiers and default bus widths.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 256;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_e;

  typedef logic grant_t;
  localparam grant_t GRANT0 = 1'b0;
  localparam grant_t GRANT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single Data_Memory port.
// One transaction per grant, a mandatory IDLE gap after each, and a watchdog.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [DATA_W-1:0] req0_data_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [DATA_W-1:0] req1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  grant_t              last_q, last_d;
  grant_t              grant;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                in_busy;

  // NOTE: every flop, including the wide latched line, is async-reset and
  // updated with <= so all state changes together on the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= GRANT1;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    write_d   = write_q;
    addr_d    = addr_q;
    data_d    = data_q;
    grant     = (req0_enable_i && req1_enable_i) ? ~last_q : grant_t'(req1_enable_i);

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req0_enable_i || req1_enable_i) begin
          // last_q records whichever port was granted, contended or not
          last_d  = grant;
          state_d = (grant == GRANT1) ? ST_BUSY1 : ST_BUSY0;
          write_d = (grant == GRANT1) ? req1_write_i : req0_write_i;
          addr_d  = (grant == GRANT1) ? req1_addr_i  : req0_addr_i;
          data_d  = (grant == GRANT1) ? req1_data_i  : req0_data_i;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_busy      = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
  assign busy_o       = in_busy;
  assign mem_enable_o = in_busy;
  assign mem_write_o  = in_busy & write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign req0_ack_o   = (state_q == ST_BUSY0) & mem_ack_i;
  assign req1_ack_o   = (state_q == ST_BUSY1) & mem_ack_i;
  assign req0_data_o  = mem_data_i;
  assign req1_data_o  = mem_data_i;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed sequences, a contention
// vector table, and randomized traffic against a transaction-level model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req0_enable_i, req0_write_i, req1_enable_i, req1_write_i;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic [DW-1:0] req0_data_i, req1_data_i;
  logic          req0_ack_o, req1_ack_o;
  logic [DW-1:0] req0_data_o, req1_data_o;
  logic          mem_enable_o, mem_write_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic          busy_o, timeout_o;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
    .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
    .req0_ack_o(req0_ack_o), .req0_data_o(req0_data_o),
    .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
    .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
    .req1_ack_o(req1_ack_o), .req1_data_o(req1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r0, r1, mack;
    logic          e_busy, e_ack0, e_ack1;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r0, input logic r1, input logic mack,
                              input logic eb, input logic ea0, input logic ea1,
                              input logic [AW-1:0] ad);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.mack = mack;
    v.e_busy = eb; v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_addr = ad;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_enable_i = 1'b0;
    req1_enable_i = 1'b0;
    mem_ack_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic exp_to);
    check({tag, ".busy"},    busy_o,       1'b0);
    check({tag, ".enable"},  mem_enable_o, 1'b0);
    check({tag, ".ack0"},    req0_ack_o,   1'b0);
    check({tag, ".ack1"},    req1_ack_o,   1'b0);
    check({tag, ".timeout"}, timeout_o,    exp_to);
  endtask

  task automatic check_busy(input string tag, input int port, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ack);
    check({tag, ".busy"},   busy_o,       1'b1);
    check({tag, ".enable"}, mem_enable_o, 1'b1);
    check({tag, ".write"},  mem_write_o,  w);
    check({tag, ".addr"},   mem_addr_o,   a);
    check({tag, ".wdata"},  mem_data_o,   d);
    check({tag, ".ack0"},   req0_ack_o,   ack && port == 0);
    check({tag, ".ack1"},   req1_ack_o,   ack && port == 1);
    check({tag, ".rdata0"}, req0_data_o,  mem_data_i);
  endtask

  // Transaction-level reference for the random phase
  logic          m_busy, m_last, m_timeout, m_write;
  int            m_port, m_elapsed, m_lat;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  initial begin
    idle_inputs();
    req0_write_i = 1'b0; req1_write_i = 1'b0;
    req0_addr_i = '0; req1_addr_i = '0;
    req0_data_i = '0; req1_data_i = '0;
    mem_data_i = {8{32'hA5A5_0F0F}};

    // Reset values
    #2;
    check_idle("rst", 1'b0);
    check("rst.write", mem_write_o, 1'b0);
    check("rst.addr",  mem_addr_o,  '0);
    check("rst.wdata", mem_data_o,  '0);
    check("rst.rdata1", req1_data_o, mem_data_i);
    do_reset();

    // Single read at 0x20, ack 10 cycles after enable
    step();
    req0_enable_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h20; req0_data_i = '0;
    #1 check("t1.wait", busy_o, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      step();
      mem_ack_i = (e == 10); mem_data_i = rand_line();
      #1 check_busy("t1", 0, 1'b0, 32'h20, '0, mem_ack_i);
    end
    step();
    idle_inputs();
    #1 check_idle("t1.gap", 1'b0);

    // Requester inputs change during BUSY0; the latched copy must hold
    step();
    req0_enable_i = 1'b1; req0_write_i = 1'b1; req0_addr_i = 32'h400; req0_data_i = 256'h5;
    for (int e = 1; e <= 4; e++) begin
      step();
      if (e == 1) begin
        req0_addr_i = '0; req0_data_i = '0; req0_write_i = 1'b0;
      end
      mem_ack_i = (e == 4);
      #1 check_busy("t4", 0, 1'b1, 32'h400, 256'h5, mem_ack_i);
    end
    step();
    idle_inputs();
    #1 check_idle("t4.gap", 1'b0);

    // Contention table: both requesters always active, memory latency 2
    do_reset();
    req0_write_i = 1'b1; req0_addr_i = 32'hA0; req0_data_i = 256'h1111;
    req1_write_i = 1'b0; req1_addr_i = 32'hB0; req1_data_i = 256'h2222;
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    for (int t = 0; t < 6; t++) begin
      logic [AW-1:0] ad;
      logic          more;
      ad   = (t % 2 == 0) ? 32'hA0 : 32'hB0;
      more = (t != 5);
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ad));
      tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, t % 2 == 0, t % 2 == 1, ad));
      tbl.push_back(mk(more, more, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    end
    foreach (tbl[i]) begin
      step();
      req0_enable_i = tbl[i].r0; req1_enable_i = tbl[i].r1; mem_ack_i = tbl[i].mack;
      #1;
      check($sformatf("tbl%0d.busy", i),   busy_o,       tbl[i].e_busy);
      check($sformatf("tbl%0d.enable", i), mem_enable_o, tbl[i].e_busy);
      check($sformatf("tbl%0d.ack0", i),   req0_ack_o,   tbl[i].e_ack0);
      check($sformatf("tbl%0d.ack1", i),   req1_ack_o,   tbl[i].e_ack1);
      if (tbl[i].e_busy) check($sformatf("tbl%0d.addr", i), mem_addr_o, tbl[i].e_addr);
    end
    idle_inputs();

    // Watchdog: memory never acks; req1 arrives while port 0 is stuck
    step();
    req0_enable_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h80;
    #1 check("wd.wait", busy_o, 1'b0);
    for (int e = 1; e <= TO; e++) begin
      step();
      if (e == 2) begin
        req1_enable_i = 1'b1; req1_write_i = 1'b0; req1_addr_i = 32'hC0;
      end
      #1;
      check("wd.busy", busy_o, 1'b1);
      check("wd.ack0", req0_ack_o, 1'b0);
      check("wd.timeout", timeout_o, 1'b0);
    end
    step();
    req0_enable_i = 1'b0;
    #1 check_idle("wd.exit", 1'b1);
    step();
    mem_ack_i = 1'b1;
    #1 check_busy("wd.next", 1, 1'b0, 32'hC0, req1_data_i, 1'b1);
    check("wd.sticky", timeout_o, 1'b1);
    step();
    idle_inputs();
    #1 check_idle("wd.after", 1'b1);

    // Asynchronous reset in the middle of BUSY1
    step();
    req1_enable_i = 1'b1; req1_write_i = 1'b0; req1_addr_i = 32'h300;
    step();
    mem_ack_i = 1'b1;
    #1 check("rm.ack1_pre", req1_ack_o, 1'b1);
    rst_i = 1'b1;
    #1 check_idle("rm.async", 1'b0);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    step();
    req0_enable_i = 1'b1; req1_enable_i = 1'b1;
    req0_addr_i = 32'hA0; req1_addr_i = 32'hB0;
    #1 check_idle("rm.release", 1'b0);
    step();
    mem_ack_i = 1'b1;
    #1 check_busy("rm.first", 0, req0_write_i, 32'hA0, req0_data_i, 1'b1);
    step();
    idle_inputs();
    #1 check_idle("rm.gap", 1'b0);

    // Randomized traffic against the transaction-level model
    do_reset();
    m_busy = 1'b0; m_last = 1'b1; m_timeout = 1'b0;
    m_port = 0; m_elapsed = 0; m_lat = 0;
    m_write = 1'b0; m_addr = '0; m_data = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int just_dropped;
      @(posedge clk);
      #1;
      just_dropped = -1;
      if (m_busy) begin
        if (mem_ack_i || m_elapsed == TO) begin
          if (!mem_ack_i) m_timeout = 1'b1;
          m_busy = 1'b0;
          just_dropped = m_port;
          if (m_port == 0) req0_enable_i = 1'b0; else req1_enable_i = 1'b0;
        end else begin
          m_elapsed++;
        end
      end else if (req0_enable_i || req1_enable_i) begin
        int r;
        if (req0_enable_i && req1_enable_i) m_port = m_last ? 0 : 1;
        else m_port = req1_enable_i ? 1 : 0;
        m_last = (m_port == 1);
        m_busy = 1'b1;
        m_elapsed = 1;
        m_write = m_port ? req1_write_i : req0_write_i;
        m_addr  = m_port ? req1_addr_i  : req0_addr_i;
        m_data  = m_port ? req1_data_i  : req0_data_i;
        r = $urandom_range(0, 29);
        m_lat = (r == 0) ? TO + 5 : (r == 1) ? TO : $urandom_range(1, 6);
      end
      if (!req0_enable_i && just_dropped != 0 && $urandom_range(0, 2) == 0) begin
        req0_enable_i = 1'b1; req0_write_i = 1'($urandom_range(0, 1));
        req0_addr_i = $urandom & ~32'h1F; req0_data_i = rand_line();
      end
      if (!req1_enable_i && just_dropped != 1 && $urandom_range(0, 2) == 0) begin
        req1_enable_i = 1'b1; req1_write_i = 1'($urandom_range(0, 1));
        req1_addr_i = $urandom & ~32'h1F; req1_data_i = rand_line();
      end
      if (m_busy && $urandom_range(0, 3) == 0) begin
        if (m_port == 0) begin
          req0_addr_i = $urandom; req0_data_i = rand_line(); req0_write_i = ~req0_write_i;
        end else begin
          req1_addr_i = $urandom; req1_data_i = rand_line(); req1_write_i = ~req1_write_i;
        end
      end
      mem_ack_i  = m_busy && (m_elapsed == m_lat);
      mem_data_i = rand_line();
      #1;
      check("rnd.busy",    busy_o,       m_busy);
      check("rnd.enable",  mem_enable_o, m_busy);
      check("rnd.ack0",    req0_ack_o,   m_busy && m_port == 0 && mem_ack_i);
      check("rnd.ack1",    req1_ack_o,   m_busy && m_port == 1 && mem_ack_i);
      check("rnd.timeout", timeout_o,    m_timeout);
      check("rnd.rdata1",  req1_data_o,  mem_data_i);
      if (m_busy) begin
        check("rnd.write", mem_write_o, m_write);
        check("rnd.addr",  mem_addr_o,  m_addr);
        check("rnd.wdata", mem_data_o,  m_data);
      end
    end
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single 256-bit Data_Memory port between two cache requesters: port 0 is the data cache and port 1 is the instruction cache or a future second master. It sits between the CPU-side cache controllers and Data_Memory, using the same enable/write/addr/data/ack handshake on both sides. Grants are round-robin and are held for exactly one memory transaction. A watchdog flags a memory that never acknowledges.

## Interface
Parameters:
- ADDR_W, 32: address width on all ports.
- DATA_W, 256: cache-line width on all data ports.
- TIMEOUT, 64: cycles spent in BUSY without an ack before the transaction is abandoned; must be ≥ 2.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req0_enable_i / req1_enable_i  in  1  request; held high until the matching ack.
- req0_write_i / req1_write_i  in  1  1 = write line, 0 = read line.
- req0_addr_i / req1_addr_i  in  ADDR_W  byte address of the line.
- req0_data_i / req1_data_i  in  DATA_W  write data.
- req0_ack_o / req1_ack_o  out  1  one-cycle completion pulse to the granted requester.
- req0_data_o / req1_data_o  out  DATA_W  read data, valid when the matching ack is high.
- mem_enable_o  out  1  to Data_Memory enable_i.
- mem_write_o  out  1  to Data_Memory write_i.
- mem_addr_o  out  ADDR_W  to Data_Memory addr_i.
- mem_data_o  out  DATA_W  to Data_Memory data_i.
- mem_ack_i  in  1  from Data_Memory ack_o.
- mem_data_i  in  DATA_W  from Data_Memory data_o.
- busy_o  out  1  high while in BUSY0 or BUSY1.
- timeout_o  out  1  sticky watchdog flag.

## Operation
- States are IDLE, BUSY0 and BUSY1. Reset state is IDLE. The last-grant register resets to 1, so port 0 wins the first tie.
- In IDLE, requests are sampled at the clock edge:
  - One requester active: go to that requester's BUSY state.
  - Both active: grant the port that is not the last grant, then update the last-grant register.
  - On grant, latch that requester's write, addr and data into registers.
- In BUSYn:
  - mem_enable_o = 1; mem_write_o, mem_addr_o and mem_data_o are driven from the latched registers.
  - If the requester changes or drops its inputs mid-transaction, the arbiter ignores it.
- Ack routing: reqN_ack_o = mem_ack_i while in BUSYN, combinational.
  - On that edge the FSM returns to IDLE.
  - Acks arriving in IDLE are ignored.
- Read data: req0_data_o = req1_data_o = mem_data_i (broadcast). Requesters qualify it with their own ack.
- Watchdog:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT−1 with no ack: go to IDLE, set timeout_o, issue no ack.
  - timeout_o is cleared only by rst_i.
- Reset values: all outputs 0 except the data buses, which are 0 in latched fields and mem_data_i passthrough on read data. Reset mid-transaction drops mem_enable_o immediately (asynchronous); Data_Memory is reset by the same rst_i.

## Timing
- Arbitration overhead is one cycle: a request seen at edge k gives mem_enable_o high during cycle k+1.
- Ack is zero-latency passthrough: reqN_ack_o rises in the same cycle as mem_ack_i.
- After every ack there is at least one IDLE cycle with mem_enable_o = 0. This guarantees Data_Memory sees an enable gap between back-to-back transactions.
- Back-to-back throughput is one transaction per (memory latency + 1) cycles.
- Fairness: with both requesters continuously active, grants alternate 0,1,0,1. Worst-case wait is one full transaction of the other port.
- A requester that keeps enable high after its ack is re-arbitrated on the next IDLE edge as a new request. Requesters must drop enable in the cycle after the ack.

## Structure
- Package dmem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY0=2'd1, BUSY1=2'd2);
  - grant id constants;
  - default widths.
- Single module dmem_arbiter. Round-robin selection is small enough to stay inline; no sub-module.

## Test plan
- Reset then single request: req0 read at 0x20, memory acks 10 cycles after enable. Expect mem_enable_o high for 10 cycles, one req0_ack_o pulse, req0_data_o = mem_data_i, req1_ack_o stays 0.
- Simultaneous request after reset: req0 and req1 both raise enable. Expect the first grant to port 0 (mem_addr_o = req0 addr), then port 1, with one IDLE cycle between them.
- Continuous contention, 6 transactions: expect grant order 0,1,0,1,0,1 and a mem_enable_o low cycle between each pair.
- Requester input change mid-BUSY: req0 write to 0x400 with data 0x5, then req0_addr_i changes to 0x0 during BUSY0. Expect mem_addr_o to stay 0x400 until the ack.
- Watchdog with TIMEOUT=64: memory never acks. Expect return to IDLE after 64 BUSY cycles, timeout_o = 1 and sticky, no reqN_ack_o; a pending req1 is granted next.
- Reset mid-transaction: assert rst_i during BUSY1. Expect mem_enable_o, busy_o, the ack outputs and timeout_o all 0 asynchronously, and the FSM in IDLE on release.
